// File: rtl/uart_rx_word_pkg.sv
`default_nettype none
// ============================================================================
// uart_rx_word_pkg : shared UART word-receiver types, sizes and baud helper
// Rev 1.0
// ============================================================================
package uart_rx_word_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115_200;
  localparam int BYTE_W       = 8;
  localparam int WORD_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Shared with the transmitter so both ends derive the same bit period.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_word_if.sv
`default_nettype none
// ============================================================================
// uart_rx_word_if : received-word / FIFO write-side bundle with status strobes
// Rev 1.0
// ============================================================================
interface uart_rx_word_if;
  import uart_rx_word_pkg::*;

  logic              full;
  logic [WORD_W-1:0] data_out;
  logic              wr_en;
  logic [BYTE_W-1:0] byte_out;
  logic              pulse;
  logic              frame_err;
  logic              overflow;

  modport master (
    input  full,
    output data_out, wr_en, byte_out, pulse, frame_err, overflow
  );

  modport slave (
    output full,
    input  data_out, wr_en, byte_out, pulse, frame_err, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// uart_rx_sync : 2-flop synchronizer for the idle-high serial line
// Rev 1.0
// ============================================================================
module uart_rx_sync (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);
  logic r_meta;

  // Reset to the idle level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      q      <= 1'b1;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_rx_word.sv
`default_nettype none
// ============================================================================
// uart_rx_word : 8N1 receiver packing four bytes (first byte in MSBs) per word
// Rev 1.0
// ============================================================================
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire logic      rx,
  uart_rx_word_if.master bus
);
  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic              rx_s;
  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic [WORD_W-1:0] word;
  logic [1:0]        byte_idx;
  logic [1:0]        lane;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Lane 3 holds the first byte of a word, so the lane index is 3 - byte_idx.
  assign lane = ~byte_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      word          <= '0;
      byte_idx      <= '0;
      bus.data_out  <= '0;
      bus.byte_out  <= '0;
      bus.wr_en     <= 1'b0;
      bus.pulse     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.wr_en     <= 1'b0;
      bus.pulse     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overflow  <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end

        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[BYTE_W-1:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt == '0) begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            state <= IDLE;
            if (rx_s) begin
              bus.byte_out              <= shreg;
              bus.pulse                 <= 1'b1;
              word[{lane, 3'b000} +: 8] <= shreg;
              byte_idx                  <= byte_idx + 1'b1;
              if (byte_idx == 2'd3) begin
                if (!bus.full) begin
                  bus.data_out <= {word[WORD_W-1:BYTE_W], shreg};
                  bus.wr_en    <= 1'b1;
                end else begin
                  bus.overflow <= 1'b1;
                end
              end
            end else begin
              bus.frame_err <= 1'b1;
              byte_idx      <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_word : scoreboard bench; fast-baud instance plus a 434-clk/bit one
// Rev 1.0
// ============================================================================
module tb_uart_rx_word;
  localparam int BT_A = 16 * 20;   // bit time of the fast instance (16 clks)
  localparam int BT_B = 434 * 20;  // nominal bit time of the 115200 instance
  localparam int BT_B_FAST = 8506; // transmitter running 2% fast

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  q_byte_a[$];
  logic [31:0] q_word_a[$];
  int          q_ferr_a[$];
  int          q_ovf_a[$];
  logic [7:0]  q_byte_b[$];

  uart_rx_word_if bus_a ();
  uart_rx_word_if bus_b ();

  uart_rx_word #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut_a (
    .clk (clk), .rst (rst), .rx (rx_a), .bus (bus_a)
  );

  uart_rx_word dut_b (
    .clk (clk), .rst (rst), .rx (rx_b), .bus (bus_b)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit big, input logic v);
    if (big) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bt, input bit big);
    drive(big, 1'b0);
    #(bt);
    for (int i = 0; i < 8; i++) begin
      drive(big, b[i]);
      #(bt);
    end
    drive(big, stop_bit);
    #(bt);
    drive(big, 1'b1);
  endtask

  task automatic send_ok(input logic [7:0] b);
    q_byte_a.push_back(b);
    send_frame(b, 1'b1, BT_A, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_out"},  bus_a.data_out,          32'h0);
    chk({tag, "_byte_out"},  {24'h0, bus_a.byte_out}, 32'h0);
    chk({tag, "_strobes"},   {28'h0, bus_a.wr_en, bus_a.pulse, bus_a.frame_err, bus_a.overflow}, 32'h0);
  endtask

  // Scoreboard monitor for the fast instance.
  always @(negedge clk) begin
    if (bus_a.pulse) begin
      n_checks++;
      if (q_byte_a.size() == 0) begin
        n_errors++;
        $display("FAIL pulse_a: unexpected pulse byte_out=%h", bus_a.byte_out);
      end else begin
        logic [7:0] e;
        e = q_byte_a.pop_front();
        if (bus_a.byte_out !== e) begin
          n_errors++;
          $display("FAIL byte_out_a: got %h expected %h", bus_a.byte_out, e);
        end
      end
    end
    if (bus_a.wr_en) begin
      n_checks++;
      if (q_word_a.size() == 0 || !bus_a.pulse) begin
        n_errors++;
        $display("FAIL wr_en_a: unexpected write data_out=%h pulse=%b", bus_a.data_out, bus_a.pulse);
      end else begin
        logic [31:0] e;
        e = q_word_a.pop_front();
        if (bus_a.data_out !== e) begin
          n_errors++;
          $display("FAIL data_out_a: got %h expected %h", bus_a.data_out, e);
        end
      end
    end
    if (bus_a.frame_err) begin
      n_checks++;
      if (q_ferr_a.size() == 0) begin
        n_errors++;
        $display("FAIL frame_err_a: unexpected strobe got 1 expected 0");
      end else begin
        void'(q_ferr_a.pop_front());
      end
    end
    if (bus_a.overflow) begin
      n_checks++;
      if (q_ovf_a.size() == 0 || !bus_a.pulse) begin
        n_errors++;
        $display("FAIL overflow_a: unexpected strobe got 1 expected 0 (pulse=%b)", bus_a.pulse);
      end else begin
        void'(q_ovf_a.pop_front());
      end
    end
  end

  // Scoreboard monitor for the 434-clk/bit instance.
  always @(negedge clk) begin
    if (bus_b.pulse) begin
      n_checks++;
      if (q_byte_b.size() == 0) begin
        n_errors++;
        $display("FAIL pulse_b: unexpected pulse byte_out=%h", bus_b.byte_out);
      end else begin
        logic [7:0] e;
        e = q_byte_b.pop_front();
        if (bus_b.byte_out !== e) begin
          n_errors++;
          $display("FAIL byte_out_b: got %h expected %h", bus_b.byte_out, e);
        end
      end
    end
    if (bus_b.frame_err || bus_b.wr_en || bus_b.overflow) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobes_b: got ferr=%b wr=%b ovf=%b expected 0", bus_b.frame_err, bus_b.wr_en, bus_b.overflow);
    end
  end

  initial begin
    bus_a.full = 1'b0;
    bus_b.full = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_b_outputs", {bus_b.data_out[7:0], bus_b.byte_out, 12'h0,
                            bus_b.wr_en, bus_b.pulse, bus_b.frame_err, bus_b.overflow}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    #(2 * BT_A);

    // Four back-to-back frames form one word.
    q_word_a.push_back(32'h22556633);
    send_ok(8'h22); send_ok(8'h55); send_ok(8'h66); send_ok(8'h33);
    #(2 * BT_A);

    // 100 ns low glitch, then a clean frame.
    rx_a = 1'b0; #100; rx_a = 1'b1;
    #(2 * BT_A);
    chk("glitch_state_idle", {30'h0, dut_a.state}, 32'h0);
    send_ok(8'hA5);
    #(2 * BT_A);

    // Framing error clears the partial word.
    send_ok(8'h11);
    q_ferr_a.push_back(1);
    send_frame(8'h22, 1'b0, BT_A, 1'b0);
    #(2 * BT_A);
    q_word_a.push_back(32'hAABBCCDD);
    send_ok(8'hAA); send_ok(8'hBB); send_ok(8'hCC); send_ok(8'hDD);
    #(2 * BT_A);

    // Downstream full drops the word but still strobes each byte.
    bus_a.full = 1'b1;
    q_ovf_a.push_back(1);
    send_ok(8'h01); send_ok(8'h02); send_ok(8'h03); send_ok(8'h04);
    #(2 * BT_A);
    bus_a.full = 1'b0;
    q_word_a.push_back(32'h05060708);
    send_ok(8'h05); send_ok(8'h06); send_ok(8'h07); send_ok(8'h08);
    #(2 * BT_A);
    chk("data_out_hold", bus_a.data_out, 32'h05060708);

    // Reset during bit 4 of the second byte of a word.
    send_ok(8'h12);
    rx_a = 1'b0; #(BT_A);
    for (int i = 0; i < 4; i++) begin
      rx_a = (8'h34 >> i) & 1'b1; #(BT_A);
    end
    rx_a = 1'b1;
    #(BT_A / 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midframe_reset");
    #(12 * BT_A);
    chk("post_reset_quiet_byte_out", {24'h0, bus_a.byte_out}, 32'h0);
    q_word_a.push_back(32'hDEADBEEF);
    send_ok(8'hDE); send_ok(8'hAD); send_ok(8'hBE); send_ok(8'hEF);
    #(2 * BT_A);

    // 0x55 from a transmitter 2% fast against 434 clocks per bit.
    q_byte_b.push_back(8'h55);
    send_frame(8'h55, 1'b1, BT_B_FAST, 1'b1);
    #(2 * BT_B);

    chk("pending_bytes_a", q_byte_a.size(), 32'd0);
    chk("pending_words_a", q_word_a.size(), 32'd0);
    chk("pending_ferr_a",  q_ferr_a.size(), 32'd0);
    chk("pending_ovf_a",   q_ovf_a.size(),  32'd0);
    chk("pending_bytes_b", q_byte_b.size(), 32'd0);
    chk("final_data_out_hold", bus_a.data_out, 32'hDEADBEEF);
    chk("final_byte_out_b", {24'h0, bus_b.byte_out}, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_rx_word.md
# uart_rx_word

Serial receiver paired with the existing 32-bit-word UART transmitter. It samples an 8N1 asynchronous line, recovers bytes, and packs four consecutive bytes into a 32-bit word, first byte in the MSBs. Each completed word is pushed into a downstream write-side FIFO with a single-cycle write strobe. It sits between the board RX pin and the receive FIFO feeding the Ethernet-side logic.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz (20 ns period).
- `BAUD`, 115200: line rate in bit/s.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD` (434): derived; must be ≥ 16.

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx`  in  1: asynchronous serial line; idles high.
- `full`  in  1: downstream FIFO full flag.
- `data_out`  out  32: assembled word; valid when `wr_en`=1.
- `wr_en`  out  1: one-cycle FIFO write strobe.
- `byte_out`  out  8: last received byte; valid when `pulse`=1.
- `pulse`  out  1: one-cycle strobe per correctly framed byte.
- `frame_err`  out  1: one-cycle strobe, stop bit sampled low.
- `overflow`  out  1: one-cycle strobe, word dropped because `full`=1.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `rx_s`.
- FSM states:
  - IDLE: waits for `rx_s`=0, then loads the bit counter with `CLKS_PER_BIT/2 - 1` and goes to START.
  - START: at terminal count samples `rx_s`. A 0 reloads `CLKS_PER_BIT-1` and goes to DATA. A 1 is a glitch; return to IDLE with no strobe.
  - DATA: samples once per `CLKS_PER_BIT`, 8 bits, LSB first, shifted into the byte register. After bit 7, go to STOP.
  - STOP: samples at mid-stop-bit, then returns to IDLE immediately. This allows back-to-back frames with no idle gap.
- Stop bit = 1:
  - `byte_out` ← byte and `pulse`=1.
  - The byte is written into word lane `3 - byte_idx`, and `byte_idx` increments modulo 4.
- Stop bit = 0: `frame_err`=1, the byte is discarded, and `byte_idx` is cleared, so any partial word is dropped.
- When the 4th byte completes (`byte_idx`=3):
  - `full`=0: `data_out` ← assembled word and `wr_en`=1, in the same cycle as that byte's `pulse`.
  - `full`=1: `wr_en` stays 0, `overflow`=1, and the word is lost. `byte_idx` still wraps to 0.
- `full` is evaluated only in the cycle the word completes. There is no retry and no holding of the word.
- Reset mid-frame: the FSM goes to IDLE, `byte_idx` to 0, and the partial word is discarded. A line still low after reset is treated as a new start edge.

## Timing
- Reset values:
  - `data_out`=0, `byte_out`=0.
  - `wr_en`, `pulse`, `frame_err`, `overflow` all 0.
  - FSM in IDLE, `byte_idx`=0, synchronizer flops=1.
- All outputs are registered. Every strobe is high for exactly one cycle.
- Let T0 be the first cycle with `rx_s`=0:
  - Start sample at T0 + `CLKS_PER_BIT/2`.
  - Data bit k sample at T0 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - Stop sample at T0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
  - `pulse` / `frame_err` / `wr_en` / `overflow` are asserted in the cycle after the stop sample.
- Pin-to-`rx_s` latency is 2 cycles.
- `data_out` holds its value between writes. `byte_out` holds between pulses.

## Structure
- Shared include `uart_defs.vh`: FSM state encodings (IDLE/START/DATA/STOP) and the `CLKS_PER_BIT` derivation. The same file is used by the transmitter so both ends agree on baud.
- One natural sub-module: `uart_rx_sync`, the 2-flop synchronizer with reset-to-1. The FSM, bit counter, shifter and word packer stay in the top module.

## Test plan
- Four frames 0x22, 0x55, 0x66, 0x33 back-to-back with `full`=0 → four `pulse` strobes, with `byte_out` 0x22/0x55/0x66/0x33 in order. A single `wr_en` on the last pulse with `data_out`=32'h22556633.
- 100 ns low glitch on idle `rx` → no `pulse`, no `frame_err`, FSM back in IDLE; a following 0xA5 frame is received correctly.
- Frame 0x11, then frame 0x22 with stop bit driven 0, then 0xAA, 0xBB, 0xCC, 0xDD:
  - 0x11 gives `pulse`; the 0x22 frame gives `frame_err`=1 and clears the partial word.
  - A single `wr_en` then follows with `data_out`=32'hAABBCCDD.
- `full`=1 while sending 0x01, 0x02, 0x03, 0x04 → four pulses, `overflow`=1 once, no `wr_en`. Then `full`=0 with 0x05..0x08 → `data_out`=32'h05060708.
- `rst` asserted for one cycle during bit 4 of the second byte of a word → all outputs return to reset values. The next 4 bytes 0xDE, 0xAD, 0xBE, 0xEF → `data_out`=32'hDEADBEEF.
- Baud-edge check with `CLKS_PER_BIT`=434 and the transmitter clocked 2% fast, pattern 0x55 → byte received without `frame_err`.
